ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter CNT_W, default 16: width of the taken-branch counter.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  hold the EX/MEM register.
REQ-005 flush  in  1  load a bubble into EX/MEM.
REQ-006 in_valid  in  1  ID/EX holds a live instruction.
REQ-007 IDEX_inst1  in  4  {funct7[5], funct3}.
REQ-008 IDEX_inst2  in  5  destination register rd.
REQ-009 IDEX_PC_Out, IDEX_ReadData1, IDEX_ReadData2, IDEX_imm_data  in  64 each  PC, rs1 value, rs2 value, sign-extended immediate.
REQ-010 IDEX_ALUOp  in  2; IDEX_Branch, IDEX_MemRead, IDEX_MemtoReg, IDEX_MemWrite, IDEX_ALUSrc, IDEX_RegWrite  in  1 each  decoded control.
REQ-011 EXMEM_ALU_Result  out  64  registered ALU result or memory address.
REQ-012 EXMEM_ReadData2  out  64  registered store data.
REQ-013 EXMEM_Branch_Target  out  64  registered branch target.
REQ-014 EXMEM_rd  out  5  registered rd.
REQ-015 EXMEM_Zero, EXMEM_Branch_Taken  out  1 each  registered zero flag and branch decision.
REQ-016 EXMEM_MemRead, EXMEM_MemtoReg, EXMEM_MemWrite, EXMEM_RegWrite, EXMEM_valid  out  1 each  registered control.
REQ-017 branch_count  out  CNT_W  running count of taken branches.

Function
REQ-018 Operand A SHALL be IDEX_ReadData1; operand B SHALL be IDEX_imm_data when ALUSrc=1, else IDEX_ReadData2.
REQ-019 ALUOp decode SHALL be:
- 00 -> ADD.
- 01 -> SUB.
- 10 -> decode inst1: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0001 SLL, 0101 SRL, 1101 SRA, any other ADD.
- 11 -> decode inst1[2:0]: 000 ADD, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL when inst1[3]=0 else SRA, any other ADD.
REQ-020 Arithmetic SHALL be modulo 2^64 with no overflow flag; shift amount SHALL be operand B[5:0]; SRA SHALL sign-fill from bit 63.
REQ-021 Zero SHALL equal (ALU result == 0).
REQ-022 Branch condition SHALL decode inst1[2:0]: 000 Zero, 001 !Zero, 100 signed A<B, 101 signed A>=B, any other never taken.
REQ-023 Branch target SHALL be IDEX_PC_Out + (IDEX_imm_data << 1), modulo 2^64, computed every cycle regardless of Branch.
REQ-024 Update priority at each rising clk edge SHALL be flush > stall > load.
REQ-025 flush=1 SHALL load a bubble: EXMEM_valid, all control outputs and EXMEM_Branch_Taken = 0; all data outputs and EXMEM_rd = 0.
REQ-026 stall=1 with flush=0 SHALL hold every EX/MEM output and branch_count.
REQ-027 Load SHALL capture all data and control with 1-cycle latency; when in_valid=0 the captured value SHALL be the REQ-025 bubble.
REQ-028 On load, EXMEM_Branch_Taken SHALL be in_valid & IDEX_Branch & condition.
REQ-029 branch_count SHALL increment by 1 on each load edge that captures Branch_Taken=1, wrap from 2^CNT_W-1 to 0, and never change on stall or flush.
REQ-030 No combinational path SHALL exist from any input to any output.

Reset
REQ-031 reset=0 SHALL clear every output, including branch_count, to 0 immediately and independently of clk, including mid-stall.
REQ-032 While reset=0, clock edges SHALL be ignored; the first load SHALL occur on the first rising edge after reset returns to 1.

Verification
REQ-033 ADD: ALUOp=10, inst1=0000, RD1=5, RD2=7, ALUSrc=0, RegWrite=1, in_valid=1 -> next edge ALU_Result=12, Zero=0, RegWrite=1, valid=1.
REQ-034 SRA: ALUOp=10, inst1=1101, RD1=0x8000000000000000, RD2=0x41 -> ALU_Result=0xC000000000000000. Wrap: ADD with RD1=0xFFFFFFFFFFFFFFFF, RD2=1 -> ALU_Result=0, Zero=1.
REQ-035 BLT: ALUOp=01, Branch=1, inst1=0100, RD1=-1, RD2=1, PC=0x100, imm=8 -> Branch_Taken=1, Branch_Target=0x110, branch_count 0->1. Same stimulus with in_valid=0 -> Branch_Taken=0, branch_count unchanged.
REQ-036 Valid store (MemWrite=1) in ID/EX with stall=1 and flush=1 on the same edge -> bubble captured (valid=0, MemWrite=0). stall=1 alone for 3 edges -> all outputs unchanged.
REQ-037 branch_count=0xFFFF, then one taken branch loaded -> branch_count=0x0000.
REQ-038 reset=0 asserted between clock edges during a stall -> all outputs 0 before the next edge; reset released -> first rising edge captures the current ID/EX inputs.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX stage of a 64-bit RISC-V style pipeline and its EX/MEM pipeline register.
// The ALU, branch decision and branch target are computed combinationally; everything visible outside is registered.
module ex_mem_stage #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        IDEX_inst1,
  input  logic [4:0]        IDEX_inst2,
  input  logic [63:0]       IDEX_PC_Out,
  input  logic [63:0]       IDEX_ReadData1,
  input  logic [63:0]       IDEX_ReadData2,
  input  logic [63:0]       IDEX_imm_data,
  input  logic [1:0]        IDEX_ALUOp,
  input  logic              IDEX_Branch,
  input  logic              IDEX_MemRead,
  input  logic              IDEX_MemtoReg,
  input  logic              IDEX_MemWrite,
  input  logic              IDEX_ALUSrc,
  input  logic              IDEX_RegWrite,
  output logic [63:0]       EXMEM_ALU_Result,
  output logic [63:0]       EXMEM_ReadData2,
  output logic [63:0]       EXMEM_Branch_Target,
  output logic [4:0]        EXMEM_rd,
  output logic              EXMEM_Zero,
  output logic              EXMEM_Branch_Taken,
  output logic              EXMEM_MemRead,
  output logic              EXMEM_MemtoReg,
  output logic              EXMEM_MemWrite,
  output logic              EXMEM_RegWrite,
  output logic              EXMEM_valid,
  output logic [CNT_W-1:0]  branch_count
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef struct packed {
    logic [63:0] alu_result;
    logic [63:0] read_data2;
    logic [63:0] branch_target;
    logic [4:0]  rd;
    logic        zero;
    logic        branch_taken;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        reg_write;
    logic        valid;
  } exmem_t;

  logic [63:0]      op_a;
  logic [63:0]      op_b;
  logic [5:0]       shamt;
  alu_op_e          alu_op;
  logic [63:0]      alu_res;
  logic             alu_zero;
  logic             br_cond;
  exmem_t           exmem_d;
  exmem_t           exmem_q;
  logic [CNT_W-1:0] branch_count_d;
  logic [CNT_W-1:0] branch_count_q;

  assign op_a  = IDEX_ReadData1;
  assign op_b  = IDEX_ALUSrc ? IDEX_imm_data : IDEX_ReadData2;
  assign shamt = op_b[5:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_op = ALU_ADD;
    case (IDEX_ALUOp)
      2'b01: alu_op = ALU_SUB;
      2'b10: begin
        case (IDEX_inst1)
          4'b1000: alu_op = ALU_SUB;
          4'b0111: alu_op = ALU_AND;
          4'b0110: alu_op = ALU_OR;
          4'b0100: alu_op = ALU_XOR;
          4'b0001: alu_op = ALU_SLL;
          4'b0101: alu_op = ALU_SRL;
          4'b1101: alu_op = ALU_SRA;
          default: alu_op = ALU_ADD;
        endcase
      end
      2'b11: begin
        // Immediate forms: funct7[5] only distinguishes the right shifts.
        case (IDEX_inst1[2:0])
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b100:  alu_op = ALU_XOR;
          3'b001:  alu_op = ALU_SLL;
          3'b101:  alu_op = IDEX_inst1[3] ? ALU_SRA : ALU_SRL;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_res = op_a + op_b;
    case (alu_op)
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL: alu_res = op_a << shamt;
      ALU_SRL: alu_res = op_a >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(op_a) >>> shamt);
      default: alu_res = op_a + op_b;
    endcase
  end

  assign alu_zero = (alu_res == 64'd0);

  always_comb begin
    br_cond = 1'b0;
    case (IDEX_inst1[2:0])
      3'b000:  br_cond = alu_zero;
      3'b001:  br_cond = !alu_zero;
      3'b100:  br_cond = $signed(op_a) <  $signed(op_b);
      3'b101:  br_cond = $signed(op_a) >= $signed(op_b);
      default: br_cond = 1'b0;
    endcase
  end

  // A flushed or invalid slot loads the all-zero bubble; the counter only moves on a real load.
  always_comb begin
    exmem_d        = exmem_q;
    branch_count_d = branch_count_q;
    if (flush) begin
      exmem_d = '0;
    end else if (!stall) begin
      exmem_d = '0;
      if (in_valid) begin
        exmem_d.alu_result    = alu_res;
        exmem_d.read_data2    = IDEX_ReadData2;
        exmem_d.branch_target = IDEX_PC_Out + (IDEX_imm_data << 1);
        exmem_d.rd            = IDEX_inst2;
        exmem_d.zero          = alu_zero;
        exmem_d.branch_taken  = IDEX_Branch & br_cond;
        exmem_d.mem_read      = IDEX_MemRead;
        exmem_d.mem_to_reg    = IDEX_MemtoReg;
        exmem_d.mem_write     = IDEX_MemWrite;
        exmem_d.reg_write     = IDEX_RegWrite;
        exmem_d.valid         = 1'b1;
      end
      if (exmem_d.branch_taken) begin
        branch_count_d = branch_count_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exmem_q        <= '0;
      branch_count_q <= '0;
    end else begin
      exmem_q        <= exmem_d;
      branch_count_q <= branch_count_d;
    end
  end

  assign EXMEM_ALU_Result    = exmem_q.alu_result;
  assign EXMEM_ReadData2     = exmem_q.read_data2;
  assign EXMEM_Branch_Target = exmem_q.branch_target;
  assign EXMEM_rd            = exmem_q.rd;
  assign EXMEM_Zero          = exmem_q.zero;
  assign EXMEM_Branch_Taken  = exmem_q.branch_taken;
  assign EXMEM_MemRead       = exmem_q.mem_read;
  assign EXMEM_MemtoReg      = exmem_q.mem_to_reg;
  assign EXMEM_MemWrite      = exmem_q.mem_write;
  assign EXMEM_RegWrite      = exmem_q.reg_write;
  assign EXMEM_valid         = exmem_q.valid;
  assign branch_count        = branch_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a behavioural model checked every cycle, directed cases pinned with literals,
// and a narrow-counter instance sharing the same stimulus to exercise counter wrap.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall, flush, in_valid;
  logic [3:0]  IDEX_inst1;
  logic [4:0]  IDEX_inst2;
  logic [63:0] IDEX_PC_Out, IDEX_ReadData1, IDEX_ReadData2, IDEX_imm_data;
  logic [1:0]  IDEX_ALUOp;
  logic        IDEX_Branch, IDEX_MemRead, IDEX_MemtoReg, IDEX_MemWrite, IDEX_ALUSrc, IDEX_RegWrite;

  logic [63:0] alu_result, read_data2, branch_target;
  logic [4:0]  rd;
  logic        zero, taken, mem_read, mem_to_reg, mem_write, reg_write, valid;
  logic [15:0] count;

  logic [63:0] w_alu_result, w_read_data2, w_branch_target;
  logic [4:0]  w_rd;
  logic        w_zero, w_taken, w_mem_read, w_mem_to_reg, w_mem_write, w_reg_write, w_valid;
  logic [3:0]  w_count;

  int n_tests = 0;
  int n_fail  = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .IDEX_inst1(IDEX_inst1), .IDEX_inst2(IDEX_inst2), .IDEX_PC_Out(IDEX_PC_Out),
    .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2), .IDEX_imm_data(IDEX_imm_data),
    .IDEX_ALUOp(IDEX_ALUOp), .IDEX_Branch(IDEX_Branch), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_MemWrite(IDEX_MemWrite), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_RegWrite(IDEX_RegWrite),
    .EXMEM_ALU_Result(alu_result), .EXMEM_ReadData2(read_data2), .EXMEM_Branch_Target(branch_target),
    .EXMEM_rd(rd), .EXMEM_Zero(zero), .EXMEM_Branch_Taken(taken), .EXMEM_MemRead(mem_read),
    .EXMEM_MemtoReg(mem_to_reg), .EXMEM_MemWrite(mem_write), .EXMEM_RegWrite(reg_write),
    .EXMEM_valid(valid), .branch_count(count)
  );

  ex_mem_stage #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .IDEX_inst1(IDEX_inst1), .IDEX_inst2(IDEX_inst2), .IDEX_PC_Out(IDEX_PC_Out),
    .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2), .IDEX_imm_data(IDEX_imm_data),
    .IDEX_ALUOp(IDEX_ALUOp), .IDEX_Branch(IDEX_Branch), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_MemWrite(IDEX_MemWrite), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_RegWrite(IDEX_RegWrite),
    .EXMEM_ALU_Result(w_alu_result), .EXMEM_ReadData2(w_read_data2), .EXMEM_Branch_Target(w_branch_target),
    .EXMEM_rd(w_rd), .EXMEM_Zero(w_zero), .EXMEM_Branch_Taken(w_taken), .EXMEM_MemRead(w_mem_read),
    .EXMEM_MemtoReg(w_mem_to_reg), .EXMEM_MemWrite(w_mem_write), .EXMEM_RegWrite(w_reg_write),
    .EXMEM_valid(w_valid), .branch_count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] alu, rd2, tgt;
    logic [4:0]  rd;
    logic        zero, taken, mrd, m2r, mwr, rwr, valid;
  } exp_t;

  exp_t        m;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt_w;

  function automatic logic [63:0] model_alu(logic [1:0] aluop, logic [3:0] f, logic [63:0] a, logic [63:0] b);
    string op;
    int    s;
    op = "ADD";
    if (aluop == 2'b01) op = "SUB";
    else if (aluop == 2'b10) begin
      if      (f == 4'b1000) op = "SUB";
      else if (f == 4'b0111) op = "AND";
      else if (f == 4'b0110) op = "OR";
      else if (f == 4'b0100) op = "XOR";
      else if (f == 4'b0001) op = "SLL";
      else if (f == 4'b0101) op = "SRL";
      else if (f == 4'b1101) op = "SRA";
    end else if (aluop == 2'b11) begin
      if      (f[2:0] == 3'b111) op = "AND";
      else if (f[2:0] == 3'b110) op = "OR";
      else if (f[2:0] == 3'b100) op = "XOR";
      else if (f[2:0] == 3'b001) op = "SLL";
      else if (f[2:0] == 3'b101) op = f[3] ? "SRA" : "SRL";
    end
    s = int'(b[5:0]);
    if (op == "SUB") return a - b;
    if (op == "AND") return a & b;
    if (op == "OR")  return a | b;
    if (op == "XOR") return a ^ b;
    if (op == "SLL") return a << s;
    if (op == "SRL") return a >> s;
    if (op == "SRA") return (a >> s) | (a[63] ? ~(~64'd0 >> s) : 64'd0);
    return a + b;
  endfunction

  function automatic exp_t model_load();
    exp_t        e;
    logic [63:0] b, r;
    logic        cond;
    e = '{default: '0};
    if (!in_valid) return e;
    b = IDEX_ALUSrc ? IDEX_imm_data : IDEX_ReadData2;
    r = model_alu(IDEX_ALUOp, IDEX_inst1, IDEX_ReadData1, b);
    case (IDEX_inst1[2:0])
      3'b000:  cond = (r == 0);
      3'b001:  cond = (r != 0);
      3'b100:  cond = $signed(IDEX_ReadData1) <  $signed(b);
      3'b101:  cond = $signed(IDEX_ReadData1) >= $signed(b);
      default: cond = 1'b0;
    endcase
    e.alu   = r;
    e.rd2   = IDEX_ReadData2;
    e.tgt   = IDEX_PC_Out + IDEX_imm_data * 2;
    e.rd    = IDEX_inst2;
    e.zero  = (r == 0);
    e.taken = IDEX_Branch && cond;
    e.mrd   = IDEX_MemRead;
    e.m2r   = IDEX_MemtoReg;
    e.mwr   = IDEX_MemWrite;
    e.rwr   = IDEX_RegWrite;
    e.valid = 1'b1;
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m       <= '{default: '0};
      m_cnt   <= '0;
      m_cnt_w <= '0;
    end else if (flush) begin
      m <= '{default: '0};
    end else if (!stall) begin
      m <= model_load();
      if (model_load().taken) begin
        m_cnt   <= m_cnt + 16'd1;
        m_cnt_w <= m_cnt_w + 4'd1;
      end
    end
  end

  // Outputs are compared on the falling edge, half a cycle away from any update.
  always @(negedge clk) begin
    check("alu_result",    alu_result,    m.alu);
    check("read_data2",    read_data2,    m.rd2);
    check("branch_target", branch_target, m.tgt);
    check("rd",            64'(rd),       64'(m.rd));
    check("zero",          64'(zero),     64'(m.zero));
    check("branch_taken",  64'(taken),    64'(m.taken));
    check("mem_read",      64'(mem_read), 64'(m.mrd));
    check("mem_to_reg",    64'(mem_to_reg), 64'(m.m2r));
    check("mem_write",     64'(mem_write),  64'(m.mwr));
    check("reg_write",     64'(reg_write),  64'(m.rwr));
    check("valid",         64'(valid),      64'(m.valid));
    check("branch_count",  64'(count),      64'(m_cnt));
    check("branch_count_w", 64'(w_count),   64'(m_cnt_w));
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    stall = 0; flush = 0; in_valid = 0;
    IDEX_inst1 = '0; IDEX_inst2 = '0; IDEX_PC_Out = '0;
    IDEX_ReadData1 = '0; IDEX_ReadData2 = '0; IDEX_imm_data = '0;
    IDEX_ALUOp = '0; IDEX_Branch = 0; IDEX_MemRead = 0; IDEX_MemtoReg = 0;
    IDEX_MemWrite = 0; IDEX_ALUSrc = 0; IDEX_RegWrite = 0;
  endtask

  task automatic set_alu(input logic [1:0] aluop, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    clear_inputs();
    in_valid = 1; IDEX_ALUOp = aluop; IDEX_inst1 = f;
    IDEX_ReadData1 = a; IDEX_ReadData2 = b; IDEX_RegWrite = 1; IDEX_inst2 = 5'd3;
  endtask

  task automatic set_blt();
    set_alu(2'b01, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    IDEX_Branch = 1; IDEX_RegWrite = 0; IDEX_PC_Out = 64'h100; IDEX_imm_data = 64'd8;
  endtask

  task automatic load_edge();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return ~64'd0;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 70));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    clear_inputs();
    reset = 0;
    // Edges while in reset are ignored even with a live instruction present.
    set_alu(2'b00, 4'b0000, 64'd9, 64'd9);
    repeat (3) @(posedge clk);
    #1;
    check("reset_alu", alu_result, 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);

    @(negedge clk);
    reset = 1;
    set_alu(2'b10, 4'b0000, 64'd5, 64'd7);
    load_edge();
    check("add_result", alu_result, 64'd12);
    check("add_zero", 64'(zero), 64'd0);
    check("add_regwrite", 64'(reg_write), 64'd1);
    check("add_valid", 64'(valid), 64'd1);

    @(negedge clk);
    set_alu(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'h41);
    load_edge();
    check("sra_result", alu_result, 64'hC000_0000_0000_0000);

    @(negedge clk);
    set_alu(2'b10, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    load_edge();
    check("wrap_result", alu_result, 64'd0);
    check("wrap_zero", 64'(zero), 64'd1);

    @(negedge clk);
    set_blt();
    load_edge();
    check("blt_taken", 64'(taken), 64'd1);
    check("blt_target", branch_target, 64'h110);
    check("blt_count", 64'(count), 64'd1);

    @(negedge clk);
    set_blt();
    in_valid = 0;
    load_edge();
    check("blt_invalid_taken", 64'(taken), 64'd0);
    check("blt_invalid_count", 64'(count), 64'd1);

    @(negedge clk);
    set_alu(2'b00, 4'b0000, 64'h40, 64'h8);
    IDEX_MemWrite = 1; IDEX_RegWrite = 0; stall = 1; flush = 1;
    load_edge();
    check("flush_valid", 64'(valid), 64'd0);
    check("flush_memwrite", 64'(mem_write), 64'd0);

    @(negedge clk);
    set_alu(2'b10, 4'b0000, 64'd5, 64'd7);
    load_edge();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_blt();
      stall = 1;
      load_edge();
      check("stall_result", alu_result, 64'd12);
      check("stall_valid", 64'(valid), 64'd1);
      check("stall_taken", 64'(taken), 64'd0);
      check("stall_count", 64'(count), 64'd1);
    end

    // Narrow counter: 1 + 14 = 15, then one more wraps it to 0.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      set_blt();
      load_edge();
    end
    check("narrow_count_max", 64'(w_count), 64'hF);
    @(negedge clk);
    set_blt();
    load_edge();
    check("narrow_count_wrap", 64'(w_count), 64'h0);
    check("wide_count", 64'(count), 64'h10);

    // Asynchronous reset in the middle of a stalled cycle.
    @(negedge clk);
    set_blt();
    stall = 1;
    @(posedge clk);
    #2 reset = 0;
    #1;
    check("async_rst_result", alu_result, 64'd0);
    check("async_rst_target", branch_target, 64'd0);
    check("async_rst_valid", 64'(valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    set_alu(2'b10, 4'b0000, 64'd20, 64'd22);
    load_edge();
    check("post_rst_result", alu_result, 64'd42);
    check("post_rst_valid", 64'(valid), 64'd1);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      stall          = ($urandom_range(0, 99) < 15);
      flush          = ($urandom_range(0, 99) < 8);
      in_valid       = ($urandom_range(0, 99) < 85);
      IDEX_inst1     = 4'($urandom());
      IDEX_inst2     = 5'($urandom());
      IDEX_PC_Out    = rand64();
      IDEX_ReadData1 = rand64();
      IDEX_ReadData2 = rand64();
      IDEX_imm_data  = rand64();
      IDEX_ALUOp     = 2'($urandom());
      IDEX_Branch    = ($urandom_range(0, 1) == 1);
      IDEX_MemRead   = ($urandom_range(0, 1) == 1);
      IDEX_MemtoReg  = ($urandom_range(0, 1) == 1);
      IDEX_MemWrite  = ($urandom_range(0, 1) == 1);
      IDEX_ALUSrc    = ($urandom_range(0, 1) == 1);
      IDEX_RegWrite  = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
